// File: rtl/mul_share_arbiter.sv
// Round-robin share of one sequential start/valid multiplier between NREQ requesters.
// Captures the grantee's operands, issues a one-cycle start, waits with timeout, routes the product back.
module mul_share_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_a,
    input  logic [NREQ*DW-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    output logic [2*DW-1:0]      resp_y,
    output logic                 resp_err,
    output logic                 busy,
    output logic                 mul_start,
    output logic [DW-1:0]        mul_a,
    output logic [DW-1:0]        mul_b,
    input  logic [2*DW-1:0]      mul_y,
    input  logic                 mul_valid
);

    localparam int unsigned ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned PW    = 2 * DW;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_d;
    logic [ID_W-1:0]   grant_id, grant_id_d;
    logic [CNT_W-1:0]  cnt, cnt_d, cnt_inc;
    logic [NREQ-1:0]   req_ready_d;
    logic [NREQ-1:0]   resp_valid_d;
    logic [PW-1:0]     resp_y_d;
    logic              resp_err_d;
    logic              busy_d;
    logic              mul_start_d;
    logic [DW-1:0]     mul_a_d, mul_b_d;

    logic              hi_hit, lo_hit, grant_hit;
    logic [ID_W-1:0]   hi_sel, lo_sel, grant_sel;
    logic [DW-1:0]     sel_a, sel_b;
    logic [NREQ-1:0]   grant_oh, resp_oh;
    logic [ID_W-1:0]   rr_next;

    // Round-robin pick: first request at or above rr_ptr, else first one below it.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_sel = '0;
        lo_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                if (i >= 32'(rr_ptr)) begin
                    if (!hi_hit) begin
                        hi_hit = 1'b1;
                        hi_sel = ID_W'(i);
                    end
                end else if (!lo_hit) begin
                    lo_hit = 1'b1;
                    lo_sel = ID_W'(i);
                end
            end
        end
        grant_hit = hi_hit | lo_hit;
        grant_sel = hi_hit ? hi_sel : lo_sel;
    end

    // Operand slot of the candidate grantee.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_sel == ID_W'(i)) begin
                sel_a = req_a[i*DW +: DW];
                sel_b = req_b[i*DW +: DW];
            end
        end
    end

    assign grant_oh = NREQ'(1) << grant_sel;
    assign resp_oh  = NREQ'(1) << grant_id;
    assign rr_next  = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + ID_W'(1);
    assign cnt_inc  = cnt + CNT_W'(1);

    // Next-state and next-output logic; every output is the registered image of a *_d value.
    always_comb begin
        state_d      = state;
        rr_ptr_d     = rr_ptr;
        grant_id_d   = grant_id;
        cnt_d        = cnt;
        req_ready_d  = '0;
        resp_valid_d = '0;
        resp_y_d     = '0;
        resp_err_d   = 1'b0;
        mul_start_d  = 1'b0;
        mul_a_d      = mul_a;
        mul_b_d      = mul_b;

        unique case (state)
            S_IDLE: begin
                if (grant_hit) begin
                    grant_id_d  = grant_sel;
                    mul_a_d     = sel_a;
                    mul_b_d     = sel_b;
                    req_ready_d = grant_oh;
                    mul_start_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                // A completion on the last allowed cycle still counts as success.
                if (mul_valid) begin
                    resp_valid_d = resp_oh;
                    resp_y_d     = mul_y;
                    state_d      = S_RESP;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    resp_valid_d = resp_oh;
                    resp_err_d   = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                rr_ptr_d = rr_next;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            cnt        <= '0;
            req_ready  <= '0;
            resp_valid <= '0;
            resp_y     <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
            mul_start  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
        end else begin
            state      <= state_d;
            rr_ptr     <= rr_ptr_d;
            grant_id   <= grant_id_d;
            cnt        <= cnt_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_y     <= resp_y_d;
            resp_err   <= resp_err_d;
            busy       <= busy_d;
            mul_start  <= mul_start_d;
            mul_a      <= mul_a_d;
            mul_b      <= mul_b_d;
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed vector bench for mul_share_arbiter with a behavioural start/valid multiplier model.
module tb_mul_share_arbiter;

    localparam int unsigned NREQ    = 2;
    localparam int unsigned DW      = 8;
    localparam int unsigned TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_a, req_b;
    logic [NREQ-1:0]   req_ready, resp_valid;
    logic [2*DW-1:0]   resp_y, mul_y;
    logic              resp_err, busy, mul_start, mul_valid;
    logic [DW-1:0]     mul_a, mul_b;

    int checks   = 0;
    int failures = 0;
    int start_cnt = 0;
    int resp_cnt  = 0;

    int model_lat;
    bit model_never;
    bit spur;

    typedef struct {
        logic [1:0]  req;
        logic [7:0]  a0, b0, a1, b1;
        int          lat;
        bit          never;
        int          exp_id;
        logic [15:0] exp_y;
        bit          exp_err;
    } vec_t;

    vec_t vecs[12];

    mul_share_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_y(resp_y), .resp_err(resp_err), .busy(busy),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_y(mul_y), .mul_valid(mul_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mul_start) start_cnt <= start_cnt + 1;
        if (resp_valid != '0) resp_cnt <= resp_cnt + 1;
    end

    // Multiplier model: product returned model_lat cycles after the start pulse.
    int cd;
    initial begin
        mul_valid = 1'b0;
        mul_y     = '0;
        cd        = 0;
        forever begin
            @(negedge clk);
            mul_valid = 1'b0;
            mul_y     = '0;
            if (!rst) begin
                cd = 0;
            end else if (mul_start) begin
                cd = model_never ? 0 : model_lat;
            end else if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) begin
                    mul_valid = 1'b1;
                    mul_y     = 16'(mul_a) * 16'(mul_b);
                end
            end
            if (spur) begin
                mul_valid = 1'b1;
                mul_y     = 16'hBEEF;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] req, input logic [7:0] a0, input logic [7:0] b0,
                                input logic [7:0] a1, input logic [7:0] b1, input int lat,
                                input bit never, input int exp_id, input logic [15:0] exp_y,
                                input bit exp_err);
        vec_t v;
        v.req = req; v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1;
        v.lat = lat; v.never = never; v.exp_id = exp_id; v.exp_y = exp_y; v.exp_err = exp_err;
        return v;
    endfunction

    // Applies one vector starting from an IDLE negedge and ends on the following IDLE negedge.
    task automatic run_vec(input int n, input vec_t v);
        int          waited;
        bit          seen;
        int          s0;
        logic [1:0]  exp_oh;
        logic [7:0]  ea, eb;
        exp_oh = 2'(1 << v.exp_id);
        ea = (v.exp_id == 0) ? v.a0 : v.a1;
        eb = (v.exp_id == 0) ? v.b0 : v.b1;
        req_valid   = v.req;
        req_a       = {v.a1, v.a0};
        req_b       = {v.b1, v.b0};
        model_lat   = v.lat;
        model_never = v.never;
        s0 = start_cnt;

        waited = 0; seen = 0;
        while (!seen && waited < 40) begin
            @(negedge clk);
            waited++;
            if (req_ready != '0) seen = 1;
        end
        chk($sformatf("v%0d_ready_lat", n), 32'(waited), 32'd1);
        if (!seen) return;
        chk($sformatf("v%0d_req_ready", n), 32'(req_ready), 32'(exp_oh));
        chk($sformatf("v%0d_mul_start", n), 32'(mul_start), 32'd1);
        chk($sformatf("v%0d_mul_a", n), 32'(mul_a), 32'(ea));
        chk($sformatf("v%0d_mul_b", n), 32'(mul_b), 32'(eb));
        chk($sformatf("v%0d_busy", n), 32'(busy), 32'd1);

        waited = 0; seen = 0;
        while (!seen && waited < 40) begin
            @(negedge clk);
            waited++;
            if (resp_valid != '0) seen = 1;
        end
        chk($sformatf("v%0d_resp_lat", n), 32'(waited), v.never ? 32'(TIMEOUT + 1) : 32'(v.lat + 1));
        if (!seen) return;
        chk($sformatf("v%0d_resp_valid", n), 32'(resp_valid), 32'(exp_oh));
        chk($sformatf("v%0d_resp_y", n), 32'(resp_y), 32'(v.exp_y));
        chk($sformatf("v%0d_resp_err", n), 32'(resp_err), 32'(v.exp_err));
        chk($sformatf("v%0d_start_pulses", n), 32'(start_cnt - s0), 32'd1);

        @(negedge clk);
        chk($sformatf("v%0d_resp_pulse_end", n), 32'(resp_valid), 32'd0);
        chk($sformatf("v%0d_idle_busy", n), 32'(busy), 32'd0);
        req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int   rc0;
        int   waited;
        bit   seen;
        int   busy_seen;

        vecs[0]  = mk(2'b11,   7,   8,  5,  6,  3, 0, 0,    56, 0);
        vecs[1]  = mk(2'b11,   7,   8,  5,  6,  3, 0, 1,    30, 0);
        vecs[2]  = mk(2'b11,   7,   8,  5,  6,  1, 0, 0,    56, 0);
        vecs[3]  = mk(2'b11,   7,   8,  5,  6,  2, 0, 1,    30, 0);
        vecs[4]  = mk(2'b11,   7,   8,  5,  6,  5, 0, 0,    56, 0);
        vecs[5]  = mk(2'b11,   7,   8,  5,  6,  1, 0, 1,    30, 0);
        vecs[6]  = mk(2'b01,  12,  34,  0,  0,  9, 0, 0,   408, 0);
        vecs[7]  = mk(2'b10,   0,   0, 99, 99,  4, 0, 1,  9801, 0);
        vecs[8]  = mk(2'b01, 200,   3,  0,  0,  0, 1, 0,     0, 1);
        vecs[9]  = mk(2'b01, 255, 255,  0,  0,  2, 0, 0, 65025, 0);
        vecs[10] = mk(2'b10,   0,   0, 13, 11, 16, 0, 1,   143, 0);
        vecs[11] = mk(2'b01,   0,  77,  0,  0, 15, 0, 0,     0, 0);

        rst = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0;
        spur = 1'b0; model_lat = 1; model_never = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_y", 32'(resp_y), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mul_start", 32'(mul_start), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        chk("rst_mul_b", 32'(mul_b), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Reset while waiting on the multiplier: everything clears, no response escapes.
        req_valid = 2'b01; req_a = {8'd0, 8'd3}; req_b = {8'd0, 8'd4};
        model_never = 1'b1;
        waited = 0; seen = 0;
        while (!seen && waited < 40) begin
            @(negedge clk);
            waited++;
            if (req_ready != '0) seen = 1;
        end
        chk("midrst_grant", 32'(seen), 32'd1);
        req_valid = '0;
        repeat (3) @(negedge clk);
        chk("midrst_busy_before", 32'(busy), 32'd1);
        rc0 = resp_cnt;
        rst = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_mul_a", 32'(mul_a), 32'd0);
        chk("midrst_mul_b", 32'(mul_b), 32'd0);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        model_never = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (25) @(negedge clk);
        chk("midrst_no_resp", 32'(resp_cnt - rc0), 32'd0);

        // Spurious mul_valid while idle is ignored.
        rc0 = resp_cnt;
        busy_seen = 0;
        spur = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        spur = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        chk("spur_busy", 32'(busy_seen), 32'd0);
        chk("spur_no_resp", 32'(resp_cnt - rc0), 32'd0);
        chk("spur_resp_y", 32'(resp_y), 32'd0);

        // rr_ptr restarts at 0 after reset, then alternates.
        run_vec(12, vecs[0]);
        run_vec(13, vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
